// File: rtl/ls_pulse_output.sv
// Six-bit Avalon output port with per-bit timed pulses (START/WIDTH) and completion flags.
// Optional DONE/IRQ_MASK/irq logic is built only when LS_PULSE_OUTPUT_IRQ_EN is defined.
module ls_pulse_output (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic [5:0]  out_port,
    output logic        irq
);
    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_SET   = 3'd1;
    localparam logic [2:0] ADDR_CLEAR = 3'd2;
    localparam logic [2:0] ADDR_WIDTH = 3'd3;
    localparam logic [2:0] ADDR_START = 3'd4;
    localparam logic [2:0] ADDR_BUSY  = 3'd5;
    localparam logic [2:0] ADDR_MASK  = 3'd6;
    localparam logic [2:0] ADDR_DONE  = 3'd7;

    logic        wr;
    logic [5:0]  wbits;
    logic [5:0]  busy;
    logic [15:0] width;
    logic [15:0] cnt [6];
    logic [15:0] load_val;
    logic [5:0]  cancel_mask;
    logic [5:0]  start_mask;
    logic [5:0]  expire;
    logic [5:0]  out_next;
    logic [5:0]  irq_mask;
    logic [5:0]  done;
    logic [15:0] rd_next;

    assign wr       = chipselect & ~write_n;
    assign wbits    = writedata[5:0];
    assign load_val = (width == 16'd0) ? 16'd1 : width;

    always_comb begin
        cancel_mask = '0;
        start_mask  = '0;
        if (wr) begin
            case (address)
                ADDR_DATA:             cancel_mask = '1;
                ADDR_SET, ADDR_CLEAR:  cancel_mask = wbits;
                ADDR_START:            start_mask  = wbits;
                default:               ;
            endcase
        end
    end

    // A bit expires on the edge where its counter steps from 1 to 0.
    always_comb begin
        expire = '0;
        for (int i = 0; i < 6; i++) begin
            expire[i] = busy[i] && (cnt[i] == 16'd1);
        end
    end

    always_comb begin
        out_next = out_port & ~(expire & ~cancel_mask & ~start_mask);
        if (wr) begin
            case (address)
                ADDR_DATA:  out_next = wbits;
                ADDR_SET:   out_next = out_next | wbits;
                ADDR_CLEAR: out_next = out_next & ~wbits;
                ADDR_START: out_next = out_next | wbits;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
            busy     <= '0;
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            out_port <= out_next;
            for (int i = 0; i < 6; i++) begin
                if (start_mask[i]) begin
                    busy[i] <= 1'b1;
                    cnt[i]  <= load_val;
                end else if (cancel_mask[i]) begin
                    busy[i] <= 1'b0;
                    cnt[i]  <= '0;
                end else if (busy[i]) begin
                    cnt[i] <= cnt[i] - 16'd1;
                    if (expire[i]) busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) width <= 16'h0001;
        else if (wr && address == ADDR_WIDTH) width <= writedata;
    end

`ifdef LS_PULSE_OUTPUT_IRQ_EN
    logic [5:0] completion;
    assign completion = expire & ~cancel_mask & ~start_mask;

    // Clearing first and then OR-ing completions lets a same-edge completion win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            done     <= '0;
        end else begin
            if (wr && address == ADDR_MASK) irq_mask <= wbits;
            if (wr && address == ADDR_DONE) done <= (done & ~wbits) | completion;
            else                            done <= done | completion;
        end
    end

    assign irq = |(done & irq_mask);
`else
    assign irq_mask = '0;
    assign done     = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:  rd_next = {10'd0, out_port};
            ADDR_WIDTH: rd_next = width;
            ADDR_BUSY:  rd_next = {10'd0, busy};
            ADDR_MASK:  rd_next = {10'd0, irq_mask};
            ADDR_DONE:  rd_next = {10'd0, done};
            default:    rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end
endmodule

// File: tb/tb_ls_pulse_output.sv
// Bench for ls_pulse_output: constant vector table, directed pulse sequences and random
// traffic, all checked against a time-stamp based model of the pulse port.
module tb_ls_pulse_output;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [5:0]  out_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    ls_pulse_output dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

`ifdef LS_PULSE_OUTPUT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    // Model: each running pulse remembers the absolute cycle on which it ends.
    logic [5:0]  m_lvl;
    logic [5:0]  m_done;
    logic [5:0]  m_mask;
    logic [15:0] m_width;
    int          m_end [6];
    int          cyc = 0;
    logic [15:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] m_busy();
        logic [5:0] b;
        for (int i = 0; i < 6; i++) b[i] = (m_end[i] != 0);
        return b;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {10'd0, m_lvl};
            3'd3:    return m_width;
            3'd5:    return {10'd0, m_busy()};
            3'd6:    return {10'd0, m_mask};
            3'd7:    return {10'd0, m_done};
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_lvl = '0; m_done = '0; m_mask = '0; m_width = 16'd1;
        for (int i = 0; i < 6; i++) m_end[i] = 0;
    endtask

    task automatic model_edge(input logic wr, input logic [2:0] a, input logic [15:0] d);
        logic [5:0] touched;
        logic [5:0] compl;
        int w;
        m_rd = m_read(a);
        cyc++;
        touched = '0;
        if (wr) begin
            if (a == 3'd0) touched = '1;
            else if (a == 3'd1 || a == 3'd2 || a == 3'd4) touched = d[5:0];
        end
        compl = '0;
        for (int i = 0; i < 6; i++) begin
            if (m_end[i] != 0 && m_end[i] == cyc && !touched[i]) begin
                m_lvl[i] = 1'b0;
                m_end[i] = 0;
                compl[i] = 1'b1;
            end
        end
        w = (m_width == 0) ? 1 : int'(m_width);
        if (wr) begin
            for (int i = 0; i < 6; i++) begin
                if (touched[i] && a != 3'd4) m_end[i] = 0;
                if (touched[i] && a == 3'd4) m_end[i] = cyc + w;
            end
            case (a)
                3'd0: m_lvl = d[5:0];
                3'd1: m_lvl = m_lvl | d[5:0];
                3'd2: m_lvl = m_lvl & ~d[5:0];
                3'd3: m_width = d;
                3'd4: m_lvl = m_lvl | d[5:0];
                3'd6: if (IRQ_EN) m_mask = d[5:0];
                3'd7: if (IRQ_EN) m_done = m_done & ~d[5:0];
                default: ;
            endcase
        end
        if (IRQ_EN) m_done = m_done | compl;
    endtask

    task automatic step(input logic wr, input logic [2:0] a, input logic [15:0] d);
        chipselect = wr;
        write_n    = ~wr;
        address    = a;
        writedata  = d;
        @(posedge clk);
        model_edge(wr, a, d);
        #1;
        check("model_out_port", 32'(out_port), 32'(m_lvl));
        check("model_readdata", 32'(readdata), 32'(m_rd));
        check("model_irq", 32'(irq), 32'(|(m_done & m_mask)));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'd5, 16'd0);
    endtask

    // Counts further cycles with bit b high; hc already holds earlier high samples.
    task automatic count_high(input int b, input int limit, inout int hc);
        int n = 0;
        while (out_port[b] && n < limit) begin
            step(1'b0, 3'd5, 16'd0);
            n++;
            if (out_port[b]) hc++;
        end
        if (n >= limit) check("pulse_timeout", 32'(n), 32'(limit - 1));
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [5:0]  exp_out;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int hc;
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 6'h00, 16'h0000};
        vecs[1]  = '{1'b0, 3'd1, 16'h0000, 6'h00, 16'h0000};
        vecs[2]  = '{1'b0, 3'd2, 16'h0000, 6'h00, 16'h0000};
        vecs[3]  = '{1'b0, 3'd3, 16'h0000, 6'h00, 16'h0001};
        vecs[4]  = '{1'b0, 3'd4, 16'h0000, 6'h00, 16'h0000};
        vecs[5]  = '{1'b0, 3'd5, 16'h0000, 6'h00, 16'h0000};
        vecs[6]  = '{1'b0, 3'd6, 16'h0000, 6'h00, 16'h0000};
        vecs[7]  = '{1'b0, 3'd7, 16'h0000, 6'h00, 16'h0000};
        vecs[8]  = '{1'b1, 3'd0, 16'h002A, 6'h2A, 16'h0000};
        vecs[9]  = '{1'b1, 3'd1, 16'h0001, 6'h2B, 16'h0000};
        vecs[10] = '{1'b1, 3'd2, 16'h0008, 6'h23, 16'h0000};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 6'h23, 16'h0023};

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_port", 32'(out_port), 32'h0);
        check("reset_readdata", 32'(readdata), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            check($sformatf("vec%0d_out", v), 32'(out_port), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d_rd", v), 32'(readdata), 32'(vecs[v].exp_rd));
        end

        // Five-cycle pulse on bit 2 with interrupt.
        step(1'b1, 3'd3, 16'd5);
        step(1'b1, 3'd6, 16'h0004);
        step(1'b1, 3'd4, 16'h0004);
        hc = out_port[2] ? 1 : 0;
        step(1'b0, 3'd5, 16'd0);
        if (out_port[2]) hc++;
        check("pulse_busy", 32'(readdata), 32'h0004);
        count_high(2, 20, hc);
        check("pulse_w5_len", 32'(hc), 32'd5);
        check("pulse_w5_irq", 32'(irq), 32'(IRQ_EN));
        step(1'b0, 3'd7, 16'd0);
        check("pulse_w5_done", 32'(readdata), IRQ_EN ? 32'h4 : 32'h0);
        step(1'b1, 3'd7, 16'h0004);
        check("done_clear_irq", 32'(irq), 32'h0);

        // Retrigger after 4 cycles stretches the pulse to 14 cycles.
        step(1'b1, 3'd3, 16'd10);
        step(1'b1, 3'd4, 16'h0001);
        hc = 1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd5, 16'd0);
            if (out_port[0]) hc++;
        end
        step(1'b1, 3'd4, 16'h0001);
        if (out_port[0]) hc++;
        count_high(0, 30, hc);
        check("retrigger_len", 32'(hc), 32'd14);
        step(1'b0, 3'd7, 16'd0);
        check("retrigger_done", 32'(readdata), IRQ_EN ? 32'h1 : 32'h0);
        step(1'b1, 3'd7, 16'h003F);

        // CLEAR mid-pulse cancels without a completion.
        step(1'b1, 3'd4, 16'h0002);
        idle(2);
        step(1'b1, 3'd2, 16'h0002);
        check("cancel_low", 32'(out_port[1]), 32'h0);
        idle(12);
        step(1'b0, 3'd7, 16'd0);
        check("cancel_no_done", 32'(readdata), 32'h0);

        // WIDTH of zero gives a one-cycle pulse.
        step(1'b1, 3'd3, 16'd0);
        step(1'b1, 3'd4, 16'h0020);
        check("w0_high", 32'(out_port[5]), 32'h1);
        idle(1);
        check("w0_low", 32'(out_port[5]), 32'h0);
        step(1'b1, 3'd7, 16'h003F);

        // Maximum width; a WIDTH write mid-pulse leaves it untouched.
        step(1'b1, 3'd3, 16'hFFFF);
        step(1'b1, 3'd4, 16'h0001);
        hc = 1;
        idle(10);
        hc += 10;
        step(1'b1, 3'd3, 16'd3);
        hc++;
        count_high(0, 70000, hc);
        check("wmax_len", 32'(hc), 32'd65535);
        step(1'b1, 3'd7, 16'h003F);

        // Asynchronous reset mid-pulse.
        step(1'b1, 3'd3, 16'd5);
        step(1'b1, 3'd4, 16'h0008);
        idle(2);
        chipselect = 1'b0; write_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out_port), 32'h0);
        check("async_reset_rd", 32'(readdata), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        step(1'b0, 3'd7, 16'd0);
        check("reset_no_done", 32'(readdata), 32'h0);
        step(1'b0, 3'd3, 16'd0);
        check("reset_width", 32'(readdata), 32'h1);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic        wr;
            logic [2:0]  a;
            logic [15:0] d;
            wr = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            if (wr && a == 3'd3) d = 16'($urandom_range(0, 8));
            step(wr, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ls_pulse_output.md
LS_PULSE_OUTPUT -- requirements
Module: ls_pulse_output

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port chipselect, input, 1, Avalon slave select.
REQ-004 SHALL have port address, input, 3, register select.
REQ-005 SHALL have port write_n, input, 1, active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-006 SHALL have port writedata, input, 16, write data.
REQ-007 SHALL have port readdata, output, 16, registered read data; unused bits read 0.
REQ-008 SHALL have port out_port, output, 6, driven output pins.
REQ-009 SHALL have port irq, output, 1, pulse-complete interrupt (REQ-030).

Function
REQ-010 Register map SHALL be: 0 DATA (R/W), 1 SET (W), 2 CLEAR (W), 3 WIDTH (R/W, 16 bit), 4 START (W), 5 BUSY (R), 6 IRQ_MASK (R/W), 7 DONE (R, write-1-to-clear).
REQ-011 readdata SHALL update every cycle from the register selected by address; read latency is 1 cycle; write-only addresses (1, 2, 4) read 0.
REQ-012 DATA read SHALL return the current out_port value.
REQ-013 DATA write SHALL load out_port[5:0] from writedata[5:0] on the next edge.
REQ-014 SET write SHALL force to 1 each out_port bit whose writedata bit is 1; other bits are unchanged.
REQ-015 CLEAR write SHALL force to 0 each out_port bit whose writedata bit is 1; other bits are unchanged.
REQ-016 DATA, SET or CLEAR writes SHALL cancel any active pulse on affected bits: BUSY bit cleared, no DONE set. For DATA, all six bits are affected.
REQ-017 WIDTH SHALL hold pulse length W in clk cycles; W=0 SHALL be treated as 1.
REQ-018 A START write at edge N SHALL, for each writedata[i]=1:
- set out_port[i]=1 and BUSY[i]=1 after edge N;
- load a per-bit 16-bit down-counter with max(W,1).
REQ-019 While BUSY[i], counter[i] SHALL decrement each cycle. The edge on which counter[i] reaches 0 SHALL clear out_port[i] and BUSY[i] and set DONE[i]. The pulse is therefore high for exactly W cycles (falls at edge N+W).
REQ-020 WIDTH writes SHALL NOT alter the duration of pulses already running.
REQ-021 START on a bit already BUSY SHALL reload its counter (retrigger): output stays high and no DONE is generated for the superseded pulse.
REQ-022 Each bit SHALL have one 16-bit down-counter; the six bits are fully independent.
REQ-023 DONE write SHALL clear bits whose writedata bit is 1. If a completion occurs on the same edge for the same bit, DONE SHALL end set.
REQ-024 START and a DONE-clear on the same bit cannot coincide (single write port); no arbitration is required.

Reset
REQ-025 On reset_n=0, asynchronously:
- out_port=0, BUSY=0, DONE=0, IRQ_MASK=0;
- WIDTH=16'h0001, all counters=0, readdata=0, irq=0.
REQ-026 Reset asserted mid-pulse SHALL abort the pulse immediately with out_port low; no DONE is set after release.

Configuration
REQ-027 The feature macro SHALL be LS_PULSE_OUTPUT_IRQ_EN.
REQ-028 With LS_PULSE_OUTPUT_IRQ_EN defined:
- IRQ_MASK and DONE SHALL be implemented;
- irq = |(DONE & IRQ_MASK), combinational from registers.
REQ-029 Without LS_PULSE_OUTPUT_IRQ_EN:
- IRQ_MASK and DONE SHALL read 0 and ignore writes;
- irq SHALL be tied 0;
- pulse and port behaviour is otherwise identical.
REQ-030 irq SHALL remain asserted until the masked DONE bits are cleared or their IRQ_MASK bits are cleared.

Verification
REQ-031 Reset check: after reset, read all addresses -> out_port=0, WIDTH=1, every other register 0, irq=0.
REQ-032 Port write: DATA<=0x2A, SET<=0x01, CLEAR<=0x08 -> out_port 0x2A, then 0x2B, then 0x23; DATA read returns 0x23.
REQ-033 Pulse timing: WIDTH<=5, IRQ_MASK<=0x04, START<=0x04 at edge N:
- out_port[2] high for exactly 5 cycles, falls at edge N+5;
- BUSY=0x04 during the pulse; DONE=0x04 and irq=1 at N+5;
- DONE<=0x04 -> irq=0.
REQ-034 Retrigger and cancel:
- WIDTH<=10, START<=0x01, then START<=0x01 again 4 cycles later -> bit 0 high for 14 cycles total, a single DONE;
- START<=0x02 then CLEAR<=0x02 mid-pulse -> bit 1 low next edge, DONE[1]=0.
REQ-035 Edge cases:
- WIDTH<=0, START<=0x20 -> 1-cycle pulse on bit 5;
- WIDTH<=0xFFFF -> 65535-cycle pulse; WIDTH<=3 written mid-pulse does not shorten it;
- reset asserted mid-pulse -> out_port=0 immediately.
REQ-036 Build without LS_PULSE_OUTPUT_IRQ_EN: repeat the REQ-033 stimulus -> identical out_port waveform, irq stays 0, addresses 6 and 7 read 0.
